// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: the memory-port owner
// encoding, the default camera burst limit and the burst counter width.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    // Which requester drives the single RAM port in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_CAM  = 2'd2
    } own_e;

    // Default number of back-to-back camera grants allowed while the CPU waits.
    localparam int CAM_BURST_MAX_DEF = 8;

    // Burst counter width; covers the legal burst limit range 1..255.
    localparam int BURST_W = 8;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at SAT_MAX instead of wrapping.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears count
//   clr   : synchronous clear, wins over inc
//   inc   : count up by one unless already at SAT_MAX
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: clear first, then saturating increment, else hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
        end else if (inc && (count_q != SAT_MAX)) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous single-port data RAM (1-cycle read latency) between
// a CPU load/store port and a camera pixel-write port. The camera normally
// wins, but once it has taken CAM_BURST_MAX consecutive slots while the CPU
// waits, the CPU gets the next slot.
//
// Parameters:
//   CAM_BURST_MAX : consecutive camera grants allowed while CPU waits (1..255)
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata: CPU request (held stable while stalled)
//   cpu_rdata, cpu_rvalid           : load data / one-cycle load-valid strobe
//   cpu_stall                       : CPU requested but was not granted
//   cam_req/cam_addr/cam_wdata      : camera write (held until cam_ack)
//   cam_ack                         : camera write accepted this cycle
//   mem_we/mem_addr/mem_wdata       : RAM port controls
//   mem_rdata                       : RAM read data (one cycle after address)
// Build option:
//   DMEM_ARB_STATS_EN : adds cam_grant_cnt and cpu_stall_cnt (32-bit,
//                       saturating). Arbitration is identical either way.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int CAM_BURST_MAX = dmem_arbiter_pkg::CAM_BURST_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        cpu_stall,
    input  logic        cam_req,
    input  logic [31:0] cam_addr,
    input  logic [31:0] cam_wdata,
    output logic        cam_ack,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0] cam_grant_cnt,
    output logic [31:0] cpu_stall_cnt,
`endif
    input  logic [31:0] mem_rdata
);

    localparam logic [BURST_W-1:0] BURST_MAX_C = BURST_W'(CAM_BURST_MAX);

    logic               cam_grant;
    logic               cpu_grant;
    own_e               owner;
    logic [BURST_W-1:0] burst_count;
    logic               burst_inc;
    logic               burst_clr;
    logic               rd_pend_d;
    logic               rd_pend_q;
    logic [31:0]        rdata_hold_d;
    logic [31:0]        rdata_hold_q;

    // Grant decision: camera first unless its burst allowance is used up
    // while the CPU is waiting; nothing is granted during reset.
    always_comb begin
        cam_grant = 1'b0;
        cpu_grant = 1'b0;
        if (reset) begin
            cam_grant = 1'b0;
            cpu_grant = 1'b0;
        end else begin
            cam_grant = cam_req && (!cpu_req || (burst_count < BURST_MAX_C));
            cpu_grant = cpu_req && !cam_grant;
        end
    end

    // Encode the current port owner.
    always_comb begin
        owner = OWN_NONE;
        if (cam_grant) begin
            owner = OWN_CAM;
        end else if (cpu_grant) begin
            owner = OWN_CPU;
        end else begin
            owner = OWN_NONE;
        end
    end

    // RAM port mux; idle cycles drive zeros so the bus is quiet.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (owner)
            OWN_CPU: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_CAM: begin
                mem_we    = 1'b1;
                mem_addr  = cam_addr;
                mem_wdata = cam_wdata;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = 32'd0;
                mem_wdata = 32'd0;
            end
        endcase
    end

    assign cam_ack   = cam_grant;
    assign cpu_stall = cpu_req && !cpu_grant && !reset;

    // The burst only counts camera slots taken while the CPU is waiting;
    // it restarts once the CPU is served or the camera goes idle.
    assign burst_inc = cam_grant && cpu_req;
    assign burst_clr = cpu_grant || !cam_req;

    sat_counter #(
        .WIDTH   (BURST_W),
        .SAT_MAX (BURST_MAX_C)
    ) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (burst_clr),
        .inc   (burst_inc),
        .count (burst_count)
    );

    // Read-pending and load-data hold next-state.
    always_comb begin
        rd_pend_d    = cpu_grant && !cpu_we;
        rdata_hold_d = rdata_hold_q;
        if (cpu_rvalid) begin
            rdata_hold_d = mem_rdata;
        end else begin
            rdata_hold_d = rdata_hold_q;
        end
    end

    // Read-pending flag and load-data hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q    <= 1'b0;
            rdata_hold_q <= 32'd0;
        end else begin
            rd_pend_q    <= rd_pend_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    // Gating with reset kills a read granted just before reset asserted.
    assign cpu_rvalid = rd_pend_q && !reset;

    // Load data: live RAM data on the valid cycle, held value otherwise.
    always_comb begin
        cpu_rdata = rdata_hold_q;
        if (reset) begin
            cpu_rdata = 32'd0;
        end else if (cpu_rvalid) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = rdata_hold_q;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    sat_counter #(
        .WIDTH (32)
    ) u_cam_grant_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (cam_grant),
        .count (cam_grant_cnt)
    );

    sat_counter #(
        .WIDTH (32)
    ) u_cpu_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (cpu_stall),
        .count (cpu_stall_cnt)
    );
`endif

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter (CAM_BURST_MAX = 8) with a behavioural
// synchronous RAM. Inputs change on the falling edge; outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_stall;
    logic        cam_req;
    logic [31:0] cam_addr;
    logic [31:0] cam_wdata;
    logic        cam_ack;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] cam_grant_cnt;
    logic [31:0] cpu_stall_cnt;
`endif

    logic [31:0] ram [0:1023];

    int checks;
    int errors;

    dmem_arbiter #(.CAM_BURST_MAX(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_stall  (cpu_stall),
        .cam_req    (cam_req),
        .cam_addr   (cam_addr),
        .cam_wdata  (cam_wdata),
        .cam_ack    (cam_ack),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
`ifdef DMEM_ARB_STATS_EN
        .cam_grant_cnt (cam_grant_cnt),
        .cpu_stall_cnt (cpu_stall_cnt),
`endif
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[11:2]];
    end

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        cam_req   = 1'b0;
        cam_addr  = 32'd0;
        cam_wdata = 32'd0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0040;
        cpu_wdata = 32'h1111_2222;
        cam_req   = 1'b1;
        cam_addr  = 32'h0000_0080;
        cam_wdata = 32'h3333_4444;
        #1;
        checks++; if (cam_ack !== 1'b0) begin errors++; $display("FAIL rst_cam_ack got %0b exp 0", cam_ack); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_cpu_stall got %0b exp 0", cpu_stall); end
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_cpu_rvalid got %0b exp 0", cpu_rvalid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0b exp 0", mem_we); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL rst_cpu_rdata got %h exp 0", cpu_rdata); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0010;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_stall got %0b exp 0", cpu_stall); end
        checks++; if (mem_addr !== 32'h0000_0010 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_port got addr %h we %0b exp 10/0", mem_addr, mem_we); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %0b exp 1", cpu_rvalid); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got %h exp deadbeef", cpu_rdata); end
        @(negedge clk);
        #1;
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_drop got %0b exp 0", cpu_rvalid); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold got %h exp deadbeef", cpu_rdata); end
    endtask

    task automatic test_cam_write();
        @(negedge clk);
        cam_req   = 1'b1;
        cam_addr  = 32'h0000_0200;
        cam_wdata = 32'h00FF_00FF;
        #1;
        checks++; if (cam_ack !== 1'b1) begin errors++; $display("FAIL cam_ack got %0b exp 1", cam_ack); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0000_0200 || mem_wdata !== 32'h00FF_00FF) begin
            errors++; $display("FAIL cam_port got we %0b addr %h data %h exp 1/200/00ff00ff", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (ram[10'h080] !== 32'h00FF_00FF) begin errors++; $display("FAIL cam_ram got %h exp 00ff00ff", ram[10'h080]); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cam_keeps_hold got %h exp deadbeef", cpu_rdata); end
    endtask

    task automatic test_burst();
        logic exp_cpu;
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cpu_req   = 1'b1;
            cpu_we    = 1'b1;
            cpu_addr  = 32'h0000_0020;
            cpu_wdata = 32'h0000_1234;
            cam_req   = 1'b1;
            cam_addr  = 32'h0000_0300;
            cam_wdata = 32'h0000_0000 + 32'(i);
            exp_cpu   = (i == 8) || (i == 17);
            #1;
            checks++; if (cam_ack !== !exp_cpu) begin errors++; $display("FAIL burst_cam_ack cyc %0d got %0b exp %0b", i, cam_ack, !exp_cpu); end
            checks++; if (cpu_stall !== !exp_cpu) begin errors++; $display("FAIL burst_stall cyc %0d got %0b exp %0b", i, cpu_stall, !exp_cpu); end
            checks++; if (mem_addr !== (exp_cpu ? 32'h0000_0020 : 32'h0000_0300)) begin errors++; $display("FAIL burst_addr cyc %0d got %h", i, mem_addr); end
        end
        @(negedge clk);
        idle_inputs();
`ifdef DMEM_ARB_STATS_EN
        #1;
        checks++; if (cam_grant_cnt !== 32'd18) begin errors++; $display("FAIL stats_cam got %0d exp 18", cam_grant_cnt); end
        checks++; if (cpu_stall_cnt !== 32'd18) begin errors++; $display("FAIL stats_stall got %0d exp 18", cpu_stall_cnt); end
`endif
    endtask

    task automatic test_cam_drop();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cpu_req   = 1'b1;
            cpu_we    = 1'b1;
            cpu_addr  = 32'h0000_0024;
            cpu_wdata = 32'h0000_5678;
            cam_req   = 1'b1;
            cam_addr  = 32'h0000_0304;
            cam_wdata = 32'h0000_00AA;
            #1;
            checks++; if (cam_ack !== 1'b1) begin errors++; $display("FAIL drop_pre_ack cyc %0d got %0b exp 1", i, cam_ack); end
        end
        @(negedge clk);
        cam_req = 1'b0;
        #1;
        checks++; if (cpu_stall !== 1'b0 || mem_addr !== 32'h0000_0024) begin errors++; $display("FAIL drop_cpu_grant got stall %0b addr %h exp 0/24", cpu_stall, mem_addr); end
        // Camera returns while the CPU keeps requesting: a fresh burst of 8.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cam_req = 1'b1;
            #1;
            checks++; if (cam_ack !== (i < 8)) begin errors++; $display("FAIL drop_fresh_burst cyc %0d got %0b exp %0b", i, cam_ack, (i < 8)); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_after_read();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0010;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rar_grant got stall %0b exp 0", cpu_stall); end
        @(negedge clk);
        idle_inputs();
        reset   = 1'b1;
        cam_req = 1'b1;
        cam_addr = 32'h0000_0208;
        #1;
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rar_rvalid got %0b exp 0", cpu_rvalid); end
        checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL rar_rdata got %h exp 0", cpu_rdata); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rar_mem_we got %0b exp 0", mem_we); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin errors++; $display("FAIL rar_after got rvalid %0b rdata %h exp 0/0", cpu_rvalid, cpu_rdata); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        ram[10'h004] = 32'hDEAD_BEEF;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_cam_write();
        test_burst();
        test_cam_drop();
        test_reset_after_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter CAM_BURST_MAX, default 8: max consecutive camera grants while a CPU request waits; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cpu_req  input  1  (CPU load/store this cycle); cpu_we  input  1; cpu_addr  input  32; cpu_wdata  input  32.
REQ-005 SHALL have ports cpu_rdata  output  32  (load data); cpu_rvalid  output  1  (load data valid); cpu_stall  output  1  (hold CPU pipeline).
REQ-006 SHALL have ports cam_req  input  1  (camera pixel write pending); cam_addr  input  32; cam_wdata  input  32; cam_ack  output  1  (write accepted this cycle).
REQ-007 SHALL have ports mem_we  output  1; mem_addr  output  32; mem_wdata  output  32; mem_rdata  input  32  (synchronous single-port RAM, 1-cycle read latency).

Function
REQ-008 SHALL grant at most one requester per cycle; grant decision combinational from requests plus registered state.
REQ-009 SHALL grant camera when cam_req=1 and (cpu_req=0 or burst count < CAM_BURST_MAX); otherwise grant CPU when cpu_req=1.
REQ-010 SHALL drive mem_addr/mem_wdata from the granted port, mem_we=cpu_we on CPU grant, mem_we=1 on camera grant, mem_we=0 with mem_addr/mem_wdata=0 when nothing granted.
REQ-011 SHALL assert cam_ack in the same cycle as camera grant only; camera holds cam_addr/cam_wdata until acked.
REQ-012 SHALL assert cpu_stall=1 exactly when cpu_req=1 and CPU not granted; CPU holds its request fields stable while stalled.
REQ-013 SHALL keep burst count: increment (saturating at CAM_BURST_MAX) on each camera grant while cpu_req=1; clear on any CPU grant or any cycle with cam_req=0.
REQ-014 SHALL, one cycle after a CPU read grant (cpu_we=0), assert cpu_rvalid=1 for one cycle with cpu_rdata=mem_rdata, and capture it into a hold register.
REQ-015 SHALL drive cpu_rdata from the hold register in all other cycles; CPU write grants and camera grants do not change it.
REQ-016 SHALL, with CAM_BURST_MAX=1 and both requesters continuously active, alternate grants camera, CPU, camera, CPU.
REQ-017 SHALL give the CPU the slot after CAM_BURST_MAX consecutive camera grants even if cam_req stays high; count clears after that CPU grant.

Reset
REQ-018 SHALL, while reset=1, force cam_ack=0, cpu_stall=0, cpu_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0 regardless of requests.
REQ-019 SHALL clear burst count, read-pending flag and cpu_rdata hold register to 0 on reset; a read granted the cycle before reset asserts yields no cpu_rvalid.

Configuration
REQ-020 SHALL, with macro DMEM_ARB_STATS_EN defined, add outputs cam_grant_cnt (32) and cpu_stall_cnt (32): saturating counts of camera grants and stalled CPU cycles, cleared by reset.
REQ-021 SHALL, without DMEM_ARB_STATS_EN, omit both counters and ports; arbitration behaviour identical in both builds.

Structure
REQ-022 SHALL place the owner enum (OWN_NONE, OWN_CPU, OWN_CAM) and the default CAM_BURST_MAX constant in the shared arm package.
REQ-023 SHALL implement burst and stats counters with one sub-module sat_counter (parameter WIDTH; inputs clk, reset, clr, inc; output count).

Verification
REQ-024 SHALL test: CPU read addr 0x10 (RAM=0xDEADBEEF), no camera -> cpu_stall=0, next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, held after.
REQ-025 SHALL test: camera write 0x200/0x00FF00FF, CPU idle -> cam_ack=1 same cycle, mem_we=1, RAM[0x200]=0x00FF00FF.
REQ-026 SHALL test: CAM_BURST_MAX=8, both requesting 20 cycles -> 8 cam_ack, 1 CPU grant, 8 cam_ack, 1 CPU grant, 2 cam_ack; cpu_stall high on non-CPU cycles.
REQ-027 SHALL test: cam_req drops after 5 camera grants with CPU waiting -> CPU granted next cycle, count 0, fresh burst of 8 on return.
REQ-028 SHALL test: reset asserted the cycle after a CPU read grant -> cpu_rvalid=0, cpu_rdata=0, mem_we=0 during reset.
REQ-029 SHALL test (DMEM_ARB_STATS_EN): REQ-026 stimulus -> cam_grant_cnt=18, cpu_stall_cnt=18.
